// File: rtl/wake_ctl.sv
// wake_ctl: voice-activity wake controller. Debounces per-channel VAD, opens
// a listen session on the lowest qualified channel, and turns a classifier
// hit into a fixed-length wake pulse followed by a lockout window.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | pipeline off, waiting for any qualified channel
// LISTEN   | pipeline on, session owned by ch_sel_o, hold timer running
// WAKE     | wake_o asserted for WAKE_PULSE_CYC cycles
// COOLDOWN | lockout for COOLDOWN_CYC cycles, VAD ignored
module wake_ctl #(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_CYC   = 4,
    parameter int HOLD_CYC       = 16000000,
    parameter int WAKE_PULSE_CYC = 16,
    parameter int COOLDOWN_CYC   = 1600,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] vad_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    input  logic              wake_valid_i,
    input  logic              wake_i,
    output logic              en_o,
    output logic [CH_W-1:0]   ch_sel_o,
    output logic              wake_o,
    output logic [7:0]        wake_count_o
);

    localparam int DEB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_W  = $clog2(HOLD_CYC + 1);
    localparam int PULSE_W = $clog2(WAKE_PULSE_CYC + 1);
    localparam int COOL_W  = $clog2(COOLDOWN_CYC + 1);

    localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEBOUNCE_CYC);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYC);
    localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(WAKE_PULSE_CYC);
    localparam logic [COOL_W-1:0]  COOL_LOAD  = COOL_W'(COOLDOWN_CYC);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LISTEN   = 2'd1;
    localparam logic [1:0] ST_WAKE     = 2'd2;
    localparam logic [1:0] ST_COOLDOWN = 2'd3;

    logic [1:0]         state;
    logic [DEB_W-1:0]   deb_cnt [NUM_CH];
    logic [NUM_CH-1:0]  deb;
    logic [NUM_CH-1:0]  qual;
    logic               qual_any;
    logic               qual_sel;
    logic [CH_W-1:0]    first_sel;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [PULSE_W-1:0] pulse_cnt;
    logic [COOL_W-1:0]  cool_cnt;

    // Per-channel debounce: saturating run-length of high VAD samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                deb_cnt[c] <= '0;
            end
            deb <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!vad_i[c]) begin
                    deb_cnt[c] <= '0;
                    deb[c]     <= 1'b0;
                end else if (deb_cnt[c] != DEB_MAX) begin
                    deb_cnt[c] <= deb_cnt[c] + DEB_W'(1);
                    deb[c]     <= (deb_cnt[c] == DEB_LAST);
                end
            end
        end
    end

    assign qual     = deb & ch_mask_i;
    assign qual_any = |qual;
    assign qual_sel = qual[ch_sel_o];

    // Lowest-index qualified channel wins a new session.
    always_comb begin
        first_sel = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (qual[c]) begin
                first_sel = CH_W'(c);
            end
        end
    end

    // Session FSM with its hold/pulse/cooldown down-counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            pulse_cnt    <= '0;
            cool_cnt     <= '0;
            en_o         <= 1'b0;
            wake_o       <= 1'b0;
            ch_sel_o     <= '0;
            wake_count_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (qual_any) begin
                        state    <= ST_LISTEN;
                        ch_sel_o <= first_sel;
                        hold_cnt <= HOLD_LOAD;
                        en_o     <= 1'b1;
                    end
                end
                ST_LISTEN: begin
                    // A wake hit takes priority over a hold expiry on the same edge.
                    if (wake_valid_i && wake_i) begin
                        state     <= ST_WAKE;
                        pulse_cnt <= PULSE_LOAD;
                        en_o      <= 1'b0;
                        wake_o    <= 1'b1;
                        if (wake_count_o != 8'hFF) begin
                            wake_count_o <= wake_count_o + 8'd1;
                        end
                    end else if (qual_sel) begin
                        hold_cnt <= HOLD_LOAD;
                    end else if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                        en_o  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                ST_WAKE: begin
                    if (pulse_cnt == PULSE_W'(1)) begin
                        state    <= ST_COOLDOWN;
                        cool_cnt <= COOL_LOAD;
                        wake_o   <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt - PULSE_W'(1);
                    end
                end
                ST_COOLDOWN: begin
                    if (cool_cnt == COOL_W'(1)) begin
                        state <= ST_IDLE;
                    end else begin
                        cool_cnt <= cool_cnt - COOL_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    en_o   <= 1'b0;
                    wake_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
